// File: rtl/network_port_master_pkg.sv
// Shared widths, defaults and FSM encoding for the mesh-network port initiator.
package network_port_master_pkg;

    localparam int NETWORK_ADDRESS_WIDTH    = 4;
    localparam int CACHE_BANK_ADDRESS_WIDTH = 8;
    localparam int NET_DATA_WIDTH           = 16;
    localparam int DEFAULT_FIFO_DEPTH       = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES   = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } port_state_e;

endpackage

// File: rtl/network_port_master_request_fifo.sv
// Small synchronous request buffer; push is dropped when full, pop when empty.
module request_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_MAX = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Control state; reset empties the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/network_port_master.sv
// Initiator for one mesh-network access port: buffers client requests and
// runs them one at a time over the port lines, returning one response each.
module network_port_master
    import network_port_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = NET_DATA_WIDTH,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic                  rsp_error,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] destinationAddressOut,
    output logic                  readOut,
    output logic                  writeOut,
    output logic [DATA_WIDTH-1:0] dataOut,
    input  logic                  readReadyIn,
    input  logic [DATA_WIDTH-1:0] dataIn
);

    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FIFO_CAP = FIFO_DEPTH[CNT_W-1:0];
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    port_state_e           state_q, state_d;
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
    logic                  read_out_q, read_out_d;
    logic                  write_out_q, write_out_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign req_ready = (fifo_count != FIFO_CAP);
    assign fifo_push = req_valid && !fifo_full;
    assign {head_write, head_addr, head_data} = fifo_rdata;

    request_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_request_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({req_write, req_addr, req_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        addr_out_d  = addr_out_q;
        read_out_d  = read_out_q;
        write_out_d = write_out_q;
        data_out_d  = data_out_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_error_d = rsp_error_q;
        rsp_data_d  = rsp_data_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    addr_out_d  = head_addr;
                    data_out_d  = head_data;
                    write_out_d = head_write;
                    read_out_d  = !head_write;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                read_out_d  = 1'b0;
                write_out_d = 1'b0;
                if (write_out_q) begin
                    // Writes are posted: respond straight away.
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_data_d  = '0;
                    state_d     = ST_RESP;
                end else begin
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A readReady in the final wait cycle still counts as success.
                if (readReadyIn) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_error_d = 1'b0;
                    rsp_data_d  = dataIn;
                    state_d     = ST_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_error_d = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, timeout counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tmo_cnt_q   <= '0;
            addr_out_q  <= '0;
            read_out_q  <= 1'b0;
            write_out_q <= 1'b0;
            data_out_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            addr_out_q  <= addr_out_d;
            read_out_q  <= read_out_d;
            write_out_q <= write_out_d;
            data_out_q  <= data_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_error_q <= rsp_error_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign destinationAddressOut = addr_out_q;
    assign readOut               = read_out_q;
    assign writeOut              = write_out_q;
    assign dataOut               = data_out_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_write             = rsp_write_q;
    assign rsp_error             = rsp_error_q;
    assign rsp_data              = rsp_data_q;

endmodule
